// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller and the
// future forwarding unit.
//   state_t      : sequencing controller states (RUN / MULTI)
//   REG_ADDR_W   : register file address width
//   ZERO_REG     : hard-wired zero register, never a real hazard source
//   MULTI_CNT_W  : width of the multi-cycle hold down-counter
package pipe_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int MULTI_CNT_W = 4;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    STATE_RUN   = 1'b0,
    STATE_MULTI = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Combinational load-use hazard comparator.
// Asserts lu when the instruction in EX is a load that writes a non-zero
// register which the instruction in ID actually reads.
//   idRs, idRt         : source register fields of the ID instruction
//   idUsesRs, idUsesRt : ID instruction really reads rs / rt
//   exRd               : destination register of the EX instruction
//   exRegWrite         : EX instruction writes the register file
//   exIsLoad           : EX instruction writes memory data to a register
//   lu                 : load-use hazard
module load_use_detect
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idUsesRs,
  input  logic                  idUsesRt,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic                  exRegWrite,
  input  logic                  exIsLoad,
  output logic                  lu
);

  logic rsMatch;
  logic rtMatch;

  assign rsMatch = idUsesRs && (idRs == exRd);
  assign rtMatch = idUsesRt && (idRt == exRd);

  // Writes to the zero register are discarded, so they never create a hazard.
  assign lu = exIsLoad && exRegWrite && (exRd != ZERO_REG) && (rsMatch || rtMatch);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the ID/EX register and the front end.
// Each cycle the EX-stage register either latches new operands/control,
// latches a zero-control bubble (idexBubble), or holds (exHold).
// Priority in RUN: branch flush > multi-cycle op > load-use stall > run.
// Ports:
//   CLK, RST            : clock (rising edge), async active-high reset
//   idRs/idRt/idUses*   : ID instruction source operands
//   exRd/exRegWrite/... : EX instruction destination and type
//   exMulti             : EX instruction is a multi-cycle op (RUN only)
//   branchTaken         : EX-resolved branch/jump taken
//   pcWriteEn           : PC may update
//   ifidWriteEn         : IF/ID may latch
//   ifidFlush           : IF/ID latches a NOP
//   idexBubble          : ID/EX latches all-zero control
//   exHold              : ID/EX keeps its value
//   busy                : controller is in MULTI (exposes FSM state)
//   stallCount          : saturating count of hazard stall cycles
//   flushCount          : saturating count of branch flushes
module hazard_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MULTI_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idUsesRs,
  input  logic                  idUsesRt,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic                  exRegWrite,
  input  logic                  exIsLoad,
  input  logic                  exMulti,
  input  logic                  branchTaken,
  output logic                  pcWriteEn,
  output logic                  ifidWriteEn,
  output logic                  ifidFlush,
  output logic                  idexBubble,
  output logic                  exHold,
  output logic                  busy,
  output logic [CNT_W-1:0]      stallCount,
  output logic [CNT_W-1:0]      flushCount
);

  // The issue cycle in RUN is the first hold cycle, so MULTI lasts
  // MULTI_CYCLES-1 cycles: load MULTI_CYCLES-2 and leave when cnt hits 0.
  localparam bit MULTI_EN = (MULTI_CYCLES > 1);
  localparam logic [MULTI_CNT_W-1:0] MULTI_LOAD =
    MULTI_EN ? MULTI_CNT_W'(MULTI_CYCLES - 2) : '0;

  state_t                 state;
  state_t                 stateNext;
  logic [MULTI_CNT_W-1:0] cnt;
  logic [MULTI_CNT_W-1:0] cntNext;
  logic                   stallInc;
  logic                   flushInc;
  logic                   lu;

  load_use_detect uLoadUse (
    .idRs       (idRs),
    .idRt       (idRt),
    .idUsesRs   (idUsesRs),
    .idUsesRt   (idUsesRt),
    .exRd       (exRd),
    .exRegWrite (exRegWrite),
    .exIsLoad   (exIsLoad),
    .lu         (lu)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= STATE_RUN;
      cnt        <= '0;
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (stallInc && (stallCount != '1)) stallCount <= stallCount + CNT_W'(1);
      if (flushInc && (flushCount != '1)) flushCount <= flushCount + CNT_W'(1);
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    pcWriteEn   = 1'b0;
    ifidWriteEn = 1'b0;
    ifidFlush   = 1'b0;
    idexBubble  = 1'b0;
    exHold      = 1'b0;
    busy        = 1'b0;
    stallInc    = 1'b0;
    flushInc    = 1'b0;

    if (RST) begin
      // Front end frozen and pipeline filled with NOP/bubbles while in reset.
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
    end else begin
      unique case (state)
        STATE_RUN: begin
          if (branchTaken) begin
            // The EX instruction is the branch itself, so any load-use or
            // multi-cycle indication this cycle is stale.
            pcWriteEn   = 1'b1;
            ifidWriteEn = 1'b1;
            ifidFlush   = 1'b1;
            idexBubble  = 1'b1;
            flushInc    = 1'b1;
          end else if (exMulti && MULTI_EN) begin
            exHold    = 1'b1;
            stallInc  = 1'b1;
            cntNext   = MULTI_LOAD;
            stateNext = STATE_MULTI;
          end else if (lu) begin
            idexBubble = 1'b1;
            stallInc   = 1'b1;
          end else begin
            pcWriteEn   = 1'b1;
            ifidWriteEn = 1'b1;
          end
        end
        STATE_MULTI: begin
          exHold   = 1'b1;
          busy     = 1'b1;
          stallInc = 1'b1;
          if (cnt == '0) stateNext = STATE_RUN;
          else           cntNext   = cnt - 1'b1;
        end
        default: stateNext = STATE_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  logic       CLK;
  logic       RST;
  logic [4:0] idRs;
  logic [4:0] idRt;
  logic       idUsesRs;
  logic       idUsesRt;
  logic [4:0] exRd;
  logic       exRegWrite;
  logic       exIsLoad;
  logic       exMulti;
  logic       branchTaken;

  logic        pcWriteEn, ifidWriteEn, ifidFlush, idexBubble, exHold, busy;
  logic [31:0] stallCount, flushCount;

  logic        pcWriteEn4, ifidWriteEn4, ifidFlush4, idexBubble4, exHold4, busy4;
  logic [3:0]  stallCount4, flushCount4;

  int total;
  int bad;
  int expStall;
  int expFlush;

  hazard_stall_ctrl #(.MULTI_CYCLES(4), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .exRd(exRd), .exRegWrite(exRegWrite), .exIsLoad(exIsLoad),
    .exMulti(exMulti), .branchTaken(branchTaken),
    .pcWriteEn(pcWriteEn), .ifidWriteEn(ifidWriteEn), .ifidFlush(ifidFlush),
    .idexBubble(idexBubble), .exHold(exHold), .busy(busy),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  hazard_stall_ctrl #(.MULTI_CYCLES(4), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST),
    .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .exRd(exRd), .exRegWrite(exRegWrite), .exIsLoad(exIsLoad),
    .exMulti(exMulti), .branchTaken(branchTaken),
    .pcWriteEn(pcWriteEn4), .ifidWriteEn(ifidWriteEn4), .ifidFlush(ifidFlush4),
    .idexBubble(idexBubble4), .exHold(exHold4), .busy(busy4),
    .stallCount(stallCount4), .flushCount(flushCount4)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Driver tasks
  task automatic drive_quiet();
    idRs = 5'd0; idRt = 5'd0; idUsesRs = 1'b0; idUsesRt = 1'b0;
    exRd = 5'd0; exRegWrite = 1'b0; exIsLoad = 1'b0;
    exMulti = 1'b0; branchTaken = 1'b0;
  endtask

  task automatic drive_lu_rs(input logic [4:0] rd, input logic [4:0] rs, input logic usesRs);
    drive_quiet();
    exIsLoad = 1'b1; exRegWrite = 1'b1; exRd = rd;
    idRs = rs; idUsesRs = usesRs;
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idRs = 5'($urandom_range(0, 31)); idRt = 5'($urandom_range(0, 31));
      idUsesRs = 1'($urandom_range(0, 1)); idUsesRt = 1'($urandom_range(0, 1));
      exRd = 5'($urandom_range(0, 31)); exRegWrite = 1'($urandom_range(0, 1));
      exIsLoad = 1'($urandom_range(0, 1)); exMulti = 1'($urandom_range(0, 1));
      branchTaken = 1'($urandom_range(0, 1));
      #1;
      total++;
      if ({pcWriteEn, ifidWriteEn, ifidFlush, idexBubble, exHold, busy} !== 6'b001100) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: got %b want 001100", i,
                 {pcWriteEn, ifidWriteEn, ifidFlush, idexBubble, exHold, busy});
      end
      total++;
      if (stallCount !== 32'd0 || flushCount !== 32'd0 || stallCount4 !== 4'd0) begin
        bad++;
        $display("FAIL reset_counters: got stall=%0d flush=%0d stall4=%0d want 0",
                 stallCount, flushCount, stallCount4);
      end
      next_cycle();
    end
    drive_quiet();
    RST = 1'b0;
    #1;
    total++;
    if (pcWriteEn !== 1'b1 || ifidWriteEn !== 1'b1 || busy !== 1'b0 || idexBubble !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got pc=%b ifid=%b busy=%b bub=%b want 1 1 0 0",
               pcWriteEn, ifidWriteEn, busy, idexBubble);
    end
    next_cycle();
    total++;
    if (stallCount !== 32'd0 || flushCount !== 32'd0) begin
      bad++;
      $display("FAIL reset_quiet_counts: got stall=%0d flush=%0d want 0", stallCount, flushCount);
    end
    expStall = 0;
    expFlush = 0;
  endtask

  task automatic test_load_use();
    // Real hazard on rs
    drive_lu_rs(5'd8, 5'd8, 1'b1);
    #1;
    total++;
    if ({pcWriteEn, ifidWriteEn, idexBubble, exHold, ifidFlush} !== 5'b00100) begin
      bad++;
      $display("FAIL lu_rs_outputs: got %b want 00100",
               {pcWriteEn, ifidWriteEn, idexBubble, exHold, ifidFlush});
    end
    next_cycle();
    expStall++;
    // Destination is the zero register: no hazard
    drive_lu_rs(5'd0, 5'd0, 1'b1);
    #1;
    total++;
    if (stallCount !== 32'(expStall)) begin
      bad++;
      $display("FAIL lu_stall_count: got %0d want %0d", stallCount, expStall);
    end
    total++;
    if (pcWriteEn !== 1'b1 || idexBubble !== 1'b0) begin
      bad++;
      $display("FAIL lu_zero_reg: got pc=%b bub=%b want 1 0", pcWriteEn, idexBubble);
    end
    next_cycle();
    // rs matches but is not read
    drive_lu_rs(5'd8, 5'd8, 1'b0);
    #1;
    total++;
    if (pcWriteEn !== 1'b1 || idexBubble !== 1'b0) begin
      bad++;
      $display("FAIL lu_unused_rs: got pc=%b bub=%b want 1 0", pcWriteEn, idexBubble);
    end
    next_cycle();
    // Match on rt
    drive_lu_rs(5'd13, 5'd2, 1'b1);
    idRt = 5'd13; idUsesRt = 1'b1;
    #1;
    total++;
    if (pcWriteEn !== 1'b0 || idexBubble !== 1'b1) begin
      bad++;
      $display("FAIL lu_rt: got pc=%b bub=%b want 0 1", pcWriteEn, idexBubble);
    end
    next_cycle();
    expStall++;
    // Same match but EX is not a load
    drive_lu_rs(5'd13, 5'd13, 1'b1);
    exIsLoad = 1'b0;
    #1;
    total++;
    if (pcWriteEn !== 1'b1 || idexBubble !== 1'b0) begin
      bad++;
      $display("FAIL lu_not_load: got pc=%b bub=%b want 1 0", pcWriteEn, idexBubble);
    end
    next_cycle();
    drive_quiet();
    #1;
    total++;
    if (stallCount !== 32'(expStall)) begin
      bad++;
      $display("FAIL lu_final_count: got %0d want %0d", stallCount, expStall);
    end
  endtask

  task automatic test_branch();
    drive_lu_rs(5'd8, 5'd8, 1'b1);
    exMulti = 1'b1;
    branchTaken = 1'b1;
    #1;
    total++;
    if ({pcWriteEn, ifidWriteEn, ifidFlush, idexBubble, exHold, busy} !== 6'b111100) begin
      bad++;
      $display("FAIL branch_outputs: got %b want 111100",
               {pcWriteEn, ifidWriteEn, ifidFlush, idexBubble, exHold, busy});
    end
    next_cycle();
    expFlush++;
    drive_quiet();
    #1;
    total++;
    if (flushCount !== 32'(expFlush) || stallCount !== 32'(expStall)) begin
      bad++;
      $display("FAIL branch_counts: got flush=%0d stall=%0d want %0d %0d",
               flushCount, stallCount, expFlush, expStall);
    end
    total++;
    if (busy !== 1'b0 || pcWriteEn !== 1'b1) begin
      bad++;
      $display("FAIL branch_stays_run: got busy=%b pc=%b want 0 1", busy, pcWriteEn);
    end
    next_cycle();
  endtask

  task automatic test_multi();
    logic expHold;
    logic expBusy;
    for (int i = 0; i < 6; i++) begin
      drive_quiet();
      if (i == 0) exMulti = 1'b1;
      if (i == 2) branchTaken = 1'b1;  // must be ignored while holding
      #1;
      expHold = (i < 4);
      expBusy = (i >= 1) && (i < 4);
      total++;
      if (exHold !== expHold || busy !== expBusy || pcWriteEn !== !expHold ||
          ifidFlush !== 1'b0 || idexBubble !== 1'b0) begin
        bad++;
        $display("FAIL multi_cycle %0d: got hold=%b busy=%b pc=%b flush=%b bub=%b want %b %b %b 0 0",
                 i, exHold, busy, pcWriteEn, ifidFlush, idexBubble, expHold, expBusy, !expHold);
      end
      next_cycle();
    end
    expStall += 4;
    total++;
    if (stallCount !== 32'(expStall) || flushCount !== 32'(expFlush)) begin
      bad++;
      $display("FAIL multi_counts: got stall=%0d flush=%0d want %0d %0d",
               stallCount, flushCount, expStall, expFlush);
    end
  endtask

  task automatic test_reset_mid();
    drive_quiet();
    exMulti = 1'b1;
    next_cycle();
    exMulti = 1'b0;
    next_cycle();
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre_reset: got busy=%b want 1", busy);
    end
    RST = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || exHold !== 1'b0 || pcWriteEn !== 1'b0 || ifidFlush !== 1'b1 ||
        stallCount !== 32'd0 || flushCount !== 32'd0) begin
      bad++;
      $display("FAIL mid_async_reset: got busy=%b hold=%b pc=%b flush=%b stall=%0d fl=%0d want 0 0 0 1 0 0",
               busy, exHold, pcWriteEn, ifidFlush, stallCount, flushCount);
    end
    next_cycle();
    RST = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || pcWriteEn !== 1'b1 || exHold !== 1'b0) begin
      bad++;
      $display("FAIL mid_release: got busy=%b pc=%b hold=%b want 0 1 0", busy, pcWriteEn, exHold);
    end
    next_cycle();
    expStall = 0;
    expFlush = 0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive_lu_rs(5'd9, 5'd9, 1'b1);
      next_cycle();
      expStall++;
      if (i == 14) begin
        total++;
        if (stallCount4 !== 4'd15) begin
          bad++;
          $display("FAIL sat_reach: got %0d want 15", stallCount4);
        end
      end
    end
    drive_quiet();
    #1;
    total++;
    if (stallCount4 !== 4'd15) begin
      bad++;
      $display("FAIL sat_hold: got %0d want 15", stallCount4);
    end
    total++;
    if (stallCount !== 32'(expStall)) begin
      bad++;
      $display("FAIL sat_wide: got %0d want %0d", stallCount, expStall);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    expStall = 0;
    expFlush = 0;
    RST = 1'b1;
    drive_quiet();
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_multi();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the ID/EX pipeline register and the front end (PC, IF/ID).
- Detects load-use hazards, branch-taken flushes and multi-cycle EX operations.
- Drives stall, bubble, flush and hold enables so that the EX-stage register either latches new operands/control, latches a zero-control bubble, or holds its contents.
- Keeps saturating stall and flush performance counters.

Parameters:
- MULTI_CYCLES, 4: total EX hold cycles for a multi-cycle op (mult/div), including the issue cycle; legal range 1..16.
- CNT_W, 32: width of the performance counters.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- idRs  in  5  rs field of the instruction in ID.
- idRt  in  5  rt field of the instruction in ID.
- idUsesRs  in  1  ID instruction reads rs.
- idUsesRt  in  1  ID instruction reads rt.
- exRd  in  5  destination register of the instruction in EX, after regDst selection.
- exRegWrite  in  1  EX instruction writes the register file.
- exIsLoad  in  1  EX instruction writes memory data to a register (whatToReg = memory).
- exMulti  in  1  EX instruction is a multi-cycle op; sampled only in RUN.
- branchTaken  in  1  EX-resolved branch/jump is taken.
- pcWriteEn  out  1  PC may update.
- ifidWriteEn  out  1  IF/ID register may latch.
- ifidFlush  out  1  IF/ID register latches a NOP.
- idexBubble  out  1  ID/EX register latches all-zero control (regWrite=0, memWrite=0, branchEX=0).
- exHold  out  1  ID/EX register keeps its current value.
- busy  out  1  state is MULTI.
- stallCount  out  CNT_W  cycles with pcWriteEn=0 caused by a hazard.
- flushCount  out  CNT_W  number of branch flushes taken.

Behaviour:
- State is held in registers; outputs are combinational from state, counter and inputs.
- States:
  - RUN=0.
  - MULTI=1, with a down-counter cnt of 4 bits.
- While RST=1 (asynchronous):
  - state=RUN, cnt=0, stallCount=0, flushCount=0.
  - Outputs forced to pcWriteEn=0, ifidWriteEn=0, ifidFlush=1, idexBubble=1, exHold=0, busy=0.
- Load-use hazard (lu), defined as: exIsLoad & exRegWrite & (exRd!=0) & ((idUsesRs & idRs==exRd) | (idUsesRt & idRt==exRd)).
- RUN priority, evaluated in the same cycle:
  1. branchTaken: pcWriteEn=1, ifidFlush=1, idexBubble=1. flushCount+1. Stay in RUN. Any concurrent lu or exMulti is ignored because the EX instruction is the branch itself.
  2. exMulti with MULTI_CYCLES>1: pcWriteEn=0, ifidWriteEn=0, exHold=1. Set cnt=MULTI_CYCLES-2 and go to MULTI. stallCount+1.
  3. lu: pcWriteEn=0, ifidWriteEn=0, idexBubble=1. stallCount+1. Stay in RUN; the hazard clears on the next cycle once the load leaves EX.
  4. Otherwise: pcWriteEn=1, ifidWriteEn=1, all other enables 0.
- exMulti with MULTI_CYCLES==1 behaves as no hazard (case 4).
- MULTI:
  - Outputs: pcWriteEn=0, ifidWriteEn=0, exHold=1, busy=1. stallCount+1 each cycle.
  - If cnt==0, go to RUN next cycle; else cnt-1.
  - branchTaken, lu and exMulti are ignored in MULTI.
  - Total exHold cycles per multi op = MULTI_CYCLES exactly.
- Mutual exclusion: exHold and idexBubble are never both 1; ifidFlush and ifidWriteEn=0 are never both asserted in RUN.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-MULTI returns to RUN immediately; after reset release the first cycle is RUN case evaluation.

Decomposition:
- Shared package (pipe_pkg):
  - state enum STATE_RUN/STATE_MULTI.
  - REG_ADDR_W=5.
  - ZERO_REG=5'd0.
  - MULTI_CNT_W=4.
- One natural sub-module: load_use_detect, a purely combinational comparator producing lu, reusable later by the forwarding unit.
- Counters stay inline.

Test Plan:
- Reset: RST=1 for 3 cycles with random inputs -> pcWriteEn=0, ifidFlush=1, idexBubble=1, busy=0, counters=0; after release with quiet inputs -> pcWriteEn=1, ifidWriteEn=1.
- Load-use: exIsLoad=1, exRegWrite=1, exRd=8, idRs=8, idUsesRs=1 for one cycle -> pcWriteEn=0, idexBubble=1, stallCount=1. With exRd=0 -> no stall. With idUsesRs=0 -> no stall.
- Branch: branchTaken=1 together with lu=1 and exMulti=1 -> ifidFlush=1, idexBubble=1, pcWriteEn=1, flushCount=1, state stays RUN, stallCount unchanged.
- Multi: exMulti=1 for one cycle, MULTI_CYCLES=4 -> exHold=1 for exactly 4 consecutive cycles, busy=1 for the last 3, stallCount=4. branchTaken pulsed mid-hold -> ignored.
- Reset mid-op: RST pulsed during the 2nd MULTI cycle -> busy=0 asynchronously, counters 0, RUN after release.
- Saturation: CNT_W=4 with 20 load-use stalls -> stallCount holds at 15.
